// File: rtl/instr_fetch_ctrl.sv
// Instruction-memory / PC sequencer: streams loader words into memory in LOAD,
// drives the PC as the fetch address and picks the next PC in RUN.
module instr_fetch_ctrl #(
  parameter int          DEPTH    = 1024,
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        jump,
  input  logic [25:0] target,
  input  logic        jump_reg,
  input  logic [31:0] jump_to,
  input  logic        branch,
  input  logic        inv_zero,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic        stall,
  input  logic        halt_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [29:0] pc,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        load_ovf,
  output logic        jr_misalign
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [29:0]   pc_r;
  logic [29:0]   seq_pc;
  logic [29:0]   br_pc;
  logic          br_taken;

  // Branch offset is counted from the instruction after the branch.
  assign seq_pc   = pc_r + 30'd1;
  assign br_pc    = seq_pc + {{14{imm16[15]}}, imm16};
  assign br_taken = branch && (zero ^ inv_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      pc_r        <= RESET_PC;
      cnt         <= '0;
      load_ready  <= 1'b0;
      instr_valid <= 1'b0;
      load_ovf    <= 1'b0;
      jr_misalign <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_HALT: begin
          if (load_req) begin
            st          <= S_LOAD;
            cnt         <= '0;
            load_ovf    <= 1'b0;
            jr_misalign <= 1'b0;
            load_ready  <= 1'b1;
          end else if (start) begin
            st          <= S_RUN;
            pc_r        <= RESET_PC;
            instr_valid <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            cnt <= cnt + CW'(1);
            if (load_last) begin
              st          <= S_RUN;
              pc_r        <= RESET_PC;
              load_ready  <= 1'b0;
              instr_valid <= 1'b1;
            end else if (cnt == LAST_ADDR) begin
              st         <= S_HALT;
              load_ovf   <= 1'b1;
              load_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (halt_req) begin
            st          <= S_HALT;
            instr_valid <= 1'b0;
          end else if (stall) begin
            pc_r <= pc_r;
          end else if (jump) begin
            pc_r <= {pc_r[29:26], target};
          end else if (jump_reg) begin
            // A misaligned jr is still taken; the flag only records it.
            pc_r <= jump_to[31:2];
            if (jump_to[1:0] != 2'b00) jr_misalign <= 1'b1;
          end else if (br_taken) begin
            pc_r <= br_pc;
          end else begin
            pc_r <= seq_pc;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state    = st;
  assign pc       = pc_r;
  assign mem_we   = (st == S_LOAD) && load_valid;
  assign mem_addr = (st == S_LOAD) ? 30'(cnt) : pc_r;
  assign mem_din  = load_data;

endmodule
